// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit between the pipeline and a data memory.
// Latency: one IDLE cycle plus one or more ACCESS cycles until dmem_ready (up to MAX_WAIT), then a DONE cycle.
// Backpressure: stall_M holds the upstream pipeline while an access is outstanding; misaligned accesses never stall.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   addr_M, wdata_M           byte address and store data from EX/MEM
//   MemRead_M, MemWrite_M     access request; a write wins when both are set
//   L_type_M, S_type_M        access size (00 byte, 01 half, 1x word)
//   load_unsigned_M           zero-extend loads when set
//   stall_M                   pipeline hold
//   dmem_*                    data-memory request/response channel
//   load_data_M, load_valid   extended load result and its one-cycle strobe
//   misalign_err, timeout_err one-cycle error pulses
module mem_stage_lsu #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_M,
  input  logic [31:0] wdata_M,
  input  logic        MemRead_M,
  input  logic        MemWrite_M,
  input  logic [1:0]  L_type_M,
  input  logic [1:0]  S_type_M,
  input  logic        load_unsigned_M,
  output logic        stall_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data_M,
  output logic        load_valid,
  output logic        misalign_err,
  output logic        timeout_err
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    l_type_r;
  logic          uns_r;
  logic [1:0]    lo_r;

  logic          access, is_write, misaligned, start, timeout_hit;
  logic [1:0]    size;
  logic [3:0]    be_new;
  logic [31:0]   wdata_new;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   ld_ext;

  // Request decode and store lane placement, evaluated on the live EX/MEM inputs.
  always_comb begin
    access     = MemRead_M | MemWrite_M;
    is_write   = MemWrite_M;
    size       = is_write ? S_type_M : L_type_M;
    misaligned = ((size == 2'b01) && addr_M[0]) ||
                 (size[1] && (addr_M[1:0] != 2'b00));
    case (size)
      2'b00:   begin be_new = 4'b0001 << addr_M[1:0]; wdata_new = {4{wdata_M[7:0]}};  end
      2'b01:   begin be_new = 4'b0011 << addr_M[1:0]; wdata_new = {2{wdata_M[15:0]}}; end
      default: begin be_new = 4'b1111;                wdata_new = wdata_M;             end
    endcase
  end

  // Load lane extraction uses the fields latched at issue, not the live inputs.
  always_comb begin
    byte_sel = dmem_rdata[{lo_r, 3'b000} +: 8];
    half_sel = dmem_rdata[{lo_r[1], 4'b0000} +: 16];
    case (l_type_r)
      2'b00:   ld_ext = {{24{~uns_r & byte_sel[7]}}, byte_sel};
      2'b01:   ld_ext = {{16{~uns_r & half_sel[15]}}, half_sel};
      default: ld_ext = dmem_rdata;
    endcase
  end

  // The final waiting cycle is the one where the counter would reach MAX_WAIT,
  // so ACCESS lasts exactly MAX_WAIT cycles when the memory never answers.
  assign timeout_hit = (wait_cnt == CW'(MAX_WAIT - 1));

  always_comb begin
    state_nxt = state;
    stall_M   = 1'b0;
    dmem_req  = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (access && !misaligned) begin
          stall_M   = 1'b1;
          start     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        stall_M  = 1'b1;
        dmem_req = 1'b1;
        if (dmem_ready || timeout_hit) state_nxt = DONE;
      end
      // DONE releases the pipeline for one cycle so the same instruction cannot re-issue.
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      l_type_r     <= 2'b00;
      uns_r        <= 1'b0;
      lo_r         <= 2'b00;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= '0;
      load_data_M  <= '0;
      load_valid   <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      load_valid   <= 1'b0;
      timeout_err  <= 1'b0;
      misalign_err <= (state == IDLE) && access && misaligned;
      if (start) begin
        wait_cnt   <= '0;
        dmem_we    <= is_write;
        dmem_addr  <= {addr_M[31:2], 2'b00};
        dmem_wdata <= wdata_new;
        dmem_be    <= be_new;
        l_type_r   <= L_type_M;
        uns_r      <= load_unsigned_M;
        lo_r       <= addr_M[1:0];
      end
      if (state == ACCESS) begin
        if (dmem_ready) begin
          if (!dmem_we) begin
            load_data_M <= ld_ext;
            load_valid  <= 1'b1;
          end
        end else begin
          wait_cnt <= wait_cnt + CW'(1);
          if (timeout_hit) timeout_err <= 1'b1;
        end
      end
    end
  end

endmodule
